// File: rtl/uart_lsr_fifo.sv
// uart_lsr_fifo: first-word-fall-through FIFO with per-entry line-status tags, trigger level, overrun and flush
module uart_lsr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int ERR_W = 3,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic [ERR_W-1:0] din_err,
    input  logic             rd_en,
    input  logic             flush,
    input  logic [1:0]       trig_sel,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] dout,
    output logic [ERR_W-1:0] dout_err,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             trig_hit,
    output logic             overrun,
    output logic             err_in_fifo
);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    localparam logic [AW:0] T0 = (AW+1)'(1);
    localparam logic [AW:0] T1 = (AW+1)'(DEPTH/4);
    localparam logic [AW:0] T2 = (AW+1)'(DEPTH/2);
    localparam logic [AW:0] T3 = (AW+1)'(DEPTH-2);
    logic [ERR_W+WIDTH-1:0] mem [DEPTH];
    logic [ERR_W+WIDTH-1:0] head;
    logic [AW-1:0]          rd_ptr, wr_ptr;
    logic [AW:0]            err_cnt, trig_lvl;
    logic                   wr_ok, rd_ok, err_inc, err_dec;

    always_comb begin
        head        = mem[rd_ptr];
        full        = count == (AW+1)'(DEPTH);
        empty       = count == '0;
        wr_ok       = wr_en && (!full || rd_en);
        rd_ok       = rd_en && !empty;
        err_inc     = wr_ok && |din_err;
        err_dec     = rd_ok && |head[ERR_W+WIDTH-1:WIDTH];
        dout        = empty ? '0 : head[WIDTH-1:0];
        dout_err    = empty ? '0 : head[ERR_W+WIDTH-1:WIDTH];
        trig_lvl    = trig_sel == 2'd0 ? T0 : trig_sel == 2'd1 ? T1 : trig_sel == 2'd2 ? T2 : T3;
        trig_hit    = count >= trig_lvl;
        err_in_fifo = err_cnt != '0;
    end

    // storage has no reset; reads of stale entries are masked by empty
    always_ff @(posedge clk)
        if (rst && !flush && wr_ok)
            mem[wr_ptr] <= {din_err, din};

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok)
                rd_ptr <= rd_ptr + AW'(1);
            count   <= (wr_ok && !rd_ok) ? count + ONE : (rd_ok && !wr_ok) ? count - ONE : count;
            err_cnt <= (err_inc && !err_dec) ? err_cnt + ONE : (err_dec && !err_inc) ? err_cnt - ONE : err_cnt;
        end
    end

    // set beats clear; flush leaves the flag alone
    always_ff @(posedge clk)
        if (!rst)
            overrun <= 1'b0;
        else if (wr_en && full && !rd_en)
            overrun <= 1'b1;
        else if (ovr_clr)
            overrun <= 1'b0;
endmodule

// File: tb/tb_uart_lsr_fifo.sv
// tb_uart_lsr_fifo: directed self-checking bench for uart_lsr_fifo at default parameters
module tb_uart_lsr_fifo;
    logic       clk = 1'b0;
    logic       rst, wr_en, rd_en, flush, ovr_clr;
    logic [7:0] din, dout;
    logic [2:0] din_err, dout_err;
    logic [1:0] trig_sel;
    logic [4:0] count;
    logic       full, empty, trig_hit, overrun, err_in_fifo;
    int         n_chk = 0, n_fail = 0;
    int         lvl [4] = '{1, 4, 8, 14};

    uart_lsr_fifo dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .din_err(din_err),
        .rd_en(rd_en), .flush(flush), .trig_sel(trig_sel), .ovr_clr(ovr_clr),
        .dout(dout), .dout_err(dout_err), .count(count), .full(full),
        .empty(empty), .trig_hit(trig_hit), .overrun(overrun), .err_in_fifo(err_in_fifo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] e);
        wr_en = 1'b1; din = d; din_err = e;
        step();
        wr_en = 1'b0; din_err = 3'd0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_trig", trig_hit, 0);
        check("rst_err", err_in_fifo, 0);
        check("rst_dout", dout, 0);
        check("rst_dout_err", dout_err, 0);
        check("rst_overrun", overrun, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; ovr_clr = 1'b0;
        din = 8'd0; din_err = 3'd0; trig_sel = 2'd0;
        step(); step();
        check_reset_state();
        rst = 1'b1;
        step();

        for (int i = 0; i < 16; i++) push(8'h11 + 8'(i), 3'd0);
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        for (int i = 0; i < 16; i++) begin
            check("seq_read", dout, 8'h11 + 8'(i));
            pop();
        end
        check("drain_empty", empty, 1);
        check("drain_overrun", overrun, 0);

        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i), 3'd0);
        wr_en = 1'b1; din = 8'hAA;
        step(); step();
        wr_en = 1'b0;
        check("ovf_count", count, 16);
        check("ovf_set", overrun, 1);
        step();
        check("ovf_held", overrun, 1);
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        check("ovf_clr", overrun, 0);
        wr_en = 1'b1; ovr_clr = 1'b1; din = 8'hAA;
        step();
        wr_en = 1'b0; ovr_clr = 1'b0;
        check("ovf_set_wins", overrun, 1);
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        check("ovf_clr2", overrun, 0);

        wr_en = 1'b1; rd_en = 1'b1; din = 8'h55;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("full_rw_count", count, 16);
        check("full_rw_head", dout, 8'h41);
        for (int i = 1; i < 16; i++) begin
            check("full_rw_read", dout, 8'h40 + 8'(i));
            pop();
        end
        check("full_rw_last", dout, 8'h55);
        pop();
        check("full_rw_empty", empty, 1);

        wr_en = 1'b1; rd_en = 1'b1; din = 8'h33;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("empty_rw_count", count, 1);
        check("empty_rw_dout", dout, 8'h33);
        pop();
        check("empty_rw_drain", empty, 1);

        push(8'h01, 3'b000);
        push(8'h02, 3'b010);
        push(8'h03, 3'b000);
        check("err_set", err_in_fifo, 1);
        check("err_head_tag", dout_err, 3'b000);
        pop();
        check("err_still", err_in_fifo, 1);
        check("err_tag", dout_err, 3'b010);
        check("err_data", dout, 8'h02);
        pop();
        check("err_gone", err_in_fifo, 0);
        pop();
        check("err_empty", empty, 1);

        for (int s = 0; s < 4; s++) begin
            trig_sel = 2'(s);
            #1;
            check("trig_zero", trig_hit, 0);
            for (int k = 1; k <= 16; k++) begin
                push(8'(k), 3'd0);
                check($sformatf("trig_sel%0d_cnt%0d", s, k), trig_hit, (k >= lvl[s]) ? 1 : 0);
            end
            flush = 1'b1; step(); flush = 1'b0;
            check("trig_flush", count, 0);
        end

        trig_sel = 2'd0;
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), (i == 2) ? 3'b100 : 3'b000);
        check("pre_flush_count", count, 5);
        check("pre_flush_err", err_in_fifo, 1);
        flush = 1'b1; wr_en = 1'b1; din = 8'h77;
        step();
        flush = 1'b0; wr_en = 1'b0;
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_dout", dout, 0);
        check("flush_err", err_in_fifo, 0);

        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 3'b001);
        push(8'hEE, 3'd0);
        check("pre_rst_overrun", overrun, 1);
        rst = 1'b0; wr_en = 1'b1; rd_en = 1'b1; din = 8'h99;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check_reset_state();
        rst = 1'b1;
        step();
        check("post_rst_empty", empty, 1);
        check("post_rst_dout", dout, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_lsr_fifo.md
Name: uart_lsr_fifo

Overview:
Parametrised successor to the 16-byte UART FIFO. Stores WIDTH-bit data words, each tagged with per-entry line-status error bits (parity, framing, break). Adds a 16550-style programmable trigger level, a sticky overrun flag, an "error in FIFO" indicator and a synchronous flush. Used as the RX FIFO behind the receiver; with ERR_W error inputs tied low, it also serves as the TX FIFO.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 16, number of entries; power of two, at least 4
ERR_W, 3, error tag bits per entry: [0]=parity, [1]=framing, [2]=break
AW, log2(DEPTH), pointer width; derived, not overridden

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low: sampled on the rising edge of clk, reset when 0
wr_en  in  1  write request
din  in  WIDTH  write data
din_err  in  ERR_W  error tag written with din
rd_en  in  1  read (pop) request
flush  in  1  synchronous clear of contents (FCR clear bit)
trig_sel  in  2  trigger level select
ovr_clr  in  1  clears the overrun flag (LSR read pulse)
dout  out  WIDTH  head-of-FIFO data; combinational
dout_err  out  ERR_W  head-of-FIFO error tag; combinational
count  out  AW+1  occupancy, 0 to DEPTH
full  out  1  high when count == DEPTH
empty  out  1  high when count == 0
trig_hit  out  1  high when count >= the selected trigger level
overrun  out  1  sticky overrun flag
err_in_fifo  out  1  high when at least one stored entry has a nonzero error tag

Behaviour:
- Reset (rst==0 at a clock edge): rd_ptr, wr_ptr, count, error counter and overrun go to 0. Outputs after reset: empty=1, full=0, trig_hit=0, err_in_fifo=0, dout=0, dout_err=0. Memory contents are not cleared. Reset overrides every other input.
- Read-side outputs:
  - dout and dout_err are driven combinationally from mem[rd_ptr], so first-word-fall-through has zero latency.
  - Both are forced to 0 while empty.
  - A write into an empty FIFO is visible on dout in the cycle after the write edge.
- Write is accepted when wr_en && (!full || rd_en).
  - Writing while full is accepted if a read occurs in the same cycle; count stays at DEPTH.
  - An accepted write stores {din_err, din} at wr_ptr, and wr_ptr increments modulo DEPTH.
- Read is accepted when rd_en && !empty. rd_ptr increments modulo DEPTH. A read on an empty FIFO is ignored, even if a write happens in the same cycle.
- count update: +1 for write only, -1 for read only, unchanged when both or neither occur.
- Overrun:
  - Set on any cycle with wr_en && full && !rd_en; that write is dropped.
  - Cleared by ovr_clr.
  - If set and clear happen in the same cycle, set wins.
  - Flush does not clear overrun.
- Error counter (AW+1 bits):
  - +1 when an accepted write has din_err != 0.
  - -1 when an accepted read pops an entry whose tag != 0.
  - Unchanged when both happen in the same cycle.
  - Dropped writes do not count.
  - err_in_fifo = (error counter != 0).
- trig_sel decode: 00 -> 1, 01 -> DEPTH/4, 10 -> DEPTH/2, 11 -> DEPTH-2 (gives 1/4/8/14 at DEPTH=16). trig_hit is combinational from count.
- flush:
  - On that clock edge, pointers, count and error counter go to 0.
  - Any wr_en or rd_en in the same cycle is ignored.
  - Priority: reset > flush > read/write.
- Pointers wrap from DEPTH-1 to 0. full and empty are derived from count only, never from a pointer comparison.

Test Plan:
- Reset, then write 0x11..0x20 (16 words, tags 0); read all 16 -> full=1 after the 16th write; reads return 0x11..0x20 in order; empty=1 at the end; overrun=0.
- From full, assert wr_en without rd_en for 2 cycles with din=0xAA -> count stays 16; overrun=1 and held; 0xAA never read back; one ovr_clr pulse -> overrun=0. Repeat with ovr_clr asserted on the same cycle as the overflow write -> overrun=1.
- Full plus simultaneous wr_en/rd_en with din=0x55 -> count=16, head advances; 0x55 is read out last. Empty plus simultaneous wr_en/rd_en with din=0x33 -> count=1, dout=0x33 next cycle.
- Write 0x01 (tag 0), 0x02 (tag 3'b010), 0x03 (tag 0) -> err_in_fifo=1. Pop once -> still 1, dout_err=010. Pop again -> err_in_fifo=0.
- For trig_sel=00/01/10/11, fill one word at a time -> trig_hit rises exactly at count 1/4/8/14 (DEPTH=16).
- With 5 entries, assert flush together with wr_en -> count=0, empty=1, dout=0. Then drive rst=0 for one cycle mid-stream -> all outputs at reset values on the next cycle, including overrun=0.
